odd_parity_checker: RTL and testbench

Receives the ASCII bit-character stream produced by the odd parity generator and checks it. Each frame is `WORD_LEN` data characters ("0"/"1") followed by one parity character. The block reassembles each data word and checks that the frame carries an odd number of "1"s. It reports per-frame results and a saturating error count, and is the receive-side stage placed directly downstream of the generator.

---
 rtl/parity_pkg.sv | 14 +
 rtl/ascii_bit_decode.sv | 15 +
 rtl/odd_parity_checker.sv | 115 +++++++++++
 tb/tb_odd_parity_checker.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared ASCII constants and checker state encoding for the odd-parity
// generator/checker pair.
package parity_pkg;

  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_ONE   = 8'h31;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic {
    S_DATA = 1'b0,
    S_PAR  = 1'b1
  } chk_state_t;

endpackage

// File: rtl/ascii_bit_decode.sv
// Classifies one ASCII character as bit "0", bit "1", or anything else.
module ascii_bit_decode
  import parity_pkg::*;
(
  input  logic [8:1] ch_i,
  output logic       is_zero_o,
  output logic       is_one_o,
  output logic       is_bad_o
);

  assign is_zero_o = (ch_i == CH_ZERO);
  assign is_one_o  = (ch_i == CH_ONE);
  assign is_bad_o  = ~(is_zero_o | is_one_o);

endmodule

// File: rtl/odd_parity_checker.sv
// Reassembles WORD_LEN-bit frames from an ASCII bit stream, checks odd parity,
// and keeps a saturating count of parity errors and bad characters.
module odd_parity_checker
  import parity_pkg::*;
#(
  parameter int WORD_LEN = 8,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [8:1]          in,
  output logic                word_valid,
  output logic [WORD_LEN-1:0] word_data,
  output logic                parity_err,
  output logic                bad_char,
  output logic [CNT_W-1:0]    err_count
);

  localparam int BCNT_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WORD_LEN - 1);

  logic is_zero, is_one, is_bad;

  ascii_bit_decode u_decode (
    .ch_i      (in),
    .is_zero_o (is_zero),
    .is_one_o  (is_one),
    .is_bad_o  (is_bad)
  );

  chk_state_t          state_q, state_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [WORD_LEN-1:0] sh_q, sh_d;
  logic                acc_q, acc_d;
  logic [WORD_LEN-1:0] wdata_q, wdata_d;
  logic                wvld_q, wvld_d;
  logic                perr_q, perr_d;
  logic                bad_q, bad_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    wdata_d = wdata_q;
    wvld_d  = 1'b0;
    perr_d  = 1'b0;
    bad_d   = 1'b0;
    cnt_d   = cnt_q;

    if (in_valid) begin
      if (is_zero || is_one) begin
        if (state_q == S_DATA) begin
          sh_d  = (sh_q << 1) | WORD_LEN'(is_one);
          acc_d = acc_q ^ is_one;
          if (bcnt_q == LAST_BIT) begin
            bcnt_d  = '0;
            state_d = S_PAR;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end else begin
          wdata_d = sh_q;
          wvld_d  = 1'b1;
          perr_d  = ~(acc_q ^ is_one);
          acc_d   = 1'b0;
          state_d = S_DATA;
        end
      end else if (is_bad) begin
        // Abort the partial frame; the shifter is fully refilled by the next frame.
        bad_d   = 1'b1;
        bcnt_d  = '0;
        acc_d   = 1'b0;
        state_d = S_DATA;
      end
    end

    if ((perr_d || bad_d) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_DATA;
      bcnt_q  <= '0;
      sh_q    <= '0;
      acc_q   <= 1'b0;
      wdata_q <= '0;
      wvld_q  <= 1'b0;
      perr_q  <= 1'b0;
      bad_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      wdata_q <= wdata_d;
      wvld_q  <= wvld_d;
      perr_q  <= perr_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word_valid = wvld_q;
  assign word_data  = wdata_q;
  assign parity_err = perr_q;
  assign bad_char   = bad_q;
  assign err_count  = cnt_q;

endmodule

// File: tb/tb_odd_parity_checker.sv
// Randomized and directed bench for odd_parity_checker against a frame-level model.
module tb_odd_parity_checker;

  localparam int WL = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [8:1] in_ch = 8'h30;

  logic          wv8, pe8, bc8, wv4, pe4, bc4;
  logic [WL-1:0] wd8, wd4;
  logic [7:0]    ec8;
  logic [3:0]    ec4;

  int checks = 0;
  int failures = 0;

  bit            q[$];
  logic [WL-1:0] m_word = '0;
  int            m_c8 = 0;
  int            m_c4 = 0;

  always #5 clk = ~clk;

  odd_parity_checker #(.WORD_LEN(WL), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_ch),
    .word_valid(wv8), .word_data(wd8), .parity_err(pe8),
    .bad_char(bc8), .err_count(ec8)
  );

  odd_parity_checker #(.WORD_LEN(WL), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_ch),
    .word_valid(wv4), .word_data(wd4), .parity_err(pe4),
    .bad_char(bc4), .err_count(ec4)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_wv8"}, 32'(wv8), 0);
    chk({tag, "_wd8"}, 32'(wd8), 0);
    chk({tag, "_bc8"}, 32'(bc8), 0);
    chk({tag, "_pe8"}, 32'(pe8), 0);
    chk({tag, "_ec8"}, 32'(ec8), 0);
    chk({tag, "_ec4"}, 32'(ec4), 0);
  endtask

  // One clock of stimulus; the model works on whole frames of characters.
  task automatic step(bit v, logic [7:0] ch);
    bit e_wv = 0;
    bit e_bad = 0;
    bit e_pe = 0;
    @(negedge clk);
    in_valid = v;
    in_ch    = ch;
    if (v) begin
      if (ch != 8'h30 && ch != 8'h31) begin
        e_bad = 1;
        q.delete();
      end else begin
        q.push_back(ch == 8'h31);
        if (q.size() == WL + 1) begin
          int ones = 0;
          m_word = '0;
          for (int i = 0; i < WL; i++) m_word = (m_word << 1) | WL'(q[i]);
          for (int i = 0; i <= WL; i++) ones += int'(q[i]);
          e_wv = 1;
          e_pe = (ones % 2 == 0);
          q.delete();
        end
      end
      if (e_bad || e_pe) begin
        m_c8 = (m_c8 < 255) ? m_c8 + 1 : 255;
        m_c4 = (m_c4 < 15) ? m_c4 + 1 : 15;
      end
    end
    @(posedge clk);
    #1;
    chk("word_valid8", 32'(wv8), 32'(e_wv));
    chk("word_valid4", 32'(wv4), 32'(e_wv));
    chk("bad_char8", 32'(bc8), 32'(e_bad));
    chk("bad_char4", 32'(bc4), 32'(e_bad));
    chk("word_data8", 32'(wd8), 32'(m_word));
    chk("word_data4", 32'(wd4), 32'(m_word));
    if (e_wv) begin
      chk("parity_err8", 32'(pe8), 32'(e_pe));
      chk("parity_err4", 32'(pe4), 32'(e_pe));
    end
    chk("err_count8", 32'(ec8), 32'(m_c8));
    chk("err_count4", 32'(ec4), 32'(m_c4));
  endtask

  task automatic send_str(string s, int gap);
    for (int i = 0; i < s.len(); i++) begin
      step(1'b1, s[i]);
      repeat (gap) step(1'b0, 8'h31);
    end
  endtask

  task automatic do_reset(int cyc);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check_zero("rst_async");
    repeat (cyc) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    m_word = '0;
    m_c8   = 0;
    m_c4   = 0;
    step(1'b0, 8'h30);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 8'h30);

    send_str("10110", 0);
    chk("good_word", 32'(wd8), 32'h0000000b);
    chk("good_cnt", 32'(ec8), 0);

    send_str("11000", 0);
    chk("perr_cnt", 32'(ec8), 1);

    do_reset(2);
    send_str("10x00001", 0);
    chk("bad_word", 32'(wd8), 0);
    chk("bad_cnt", 32'(ec8), 1);

    do_reset(2);
    send_str("10110", 3);
    chk("gap_word", 32'(wd8), 32'h0000000b);
    chk("gap_cnt", 32'(ec8), 0);

    do_reset(2);
    send_str("11", 0);
    do_reset(2);
    send_str("10110", 0);
    chk("rstmid_word", 32'(wd8), 32'h0000000b);
    chk("rstmid_cnt", 32'(ec8), 0);

    do_reset(2);
    for (int f = 0; f < 20; f++) send_str("11000", 0);
    chk("sat_cnt4", 32'(ec4), 15);
    chk("sat_cnt8", 32'(ec8), 20);
    repeat (3) step(1'b1, 8'h41);
    chk("sat_hold4", 32'(ec4), 15);

    do_reset(2);
    for (int n = 0; n < 3000; n++) begin
      int r = $urandom_range(0, 99);
      if (r < 1) begin
        do_reset($urandom_range(1, 3));
      end else if (r < 16) begin
        step(1'b0, 8'($urandom_range(0, 255)));
      end else if (r < 20) begin
        step(1'b1, 8'($urandom_range(0, 255)));
      end else begin
        step(1'b1, (($urandom & 1) != 0) ? 8'h31 : 8'h30);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
